// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: parity modes, receive FSM states, tick divider helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_e;

  // System clocks per oversample tick; clamped so the divider always counts at least one cycle.
  function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
    int div;
    div = clk_freq / (baud * ovs);
    if (div < 1) begin
      div = 1;
    end
    return div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with exact occupancy count.
// Latency: a pushed word appears on head_dat the cycle after the push edge.
// Backpressure: a push while full is refused unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             do_push;
  logic             do_pop;

  // Count never exceeds DEPTH, so its top bit alone marks the full condition.
  assign empty    = (count_q == '0);
  assign full     = count_q[PTR_W];
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Next storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver (configurable frame) feeding a FWFT receive FIFO with error flags.
// Latency: frame written at the mid-sample of its final stop bit; head valid the next cycle.
// Backpressure: rx_ready pops the head; a frame completing into a full FIFO is dropped and overrun pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVS        = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PARITY_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        UART_RX,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_perr,
  output logic                        rx_ferr,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        overrun
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SUB_W = $clog2(OVS);
  localparam int CNT_W = 4;
  localparam int ENT_W = DATA_BITS + 2;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SUB_W-1:0] SUB_SAMP0 = SUB_W'(OVS / 2 - 1);
  localparam logic [SUB_W-1:0] SUB_SAMP1 = SUB_W'(OVS / 2);
  localparam logic [SUB_W-1:0] SUB_VOTE  = SUB_W'(OVS / 2 + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  // Line synchroniser and edge history
  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;
  logic rx_prev_q, rx_prev_d;

  // Tick divider, sub-tick position and majority samples
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic             samp0_q, samp0_d;
  logic             samp1_q, samp1_d;

  // Frame state
  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   overrun_q, overrun_d;

  // Combinational helpers
  logic             start_det;
  logic             tick;
  logic             vote_tick;
  logic             vote;
  logic             last_data;
  logic             last_stop;
  logic             par_exp;
  logic             push;
  logic [ENT_W-1:0] push_dat;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] head_dat;

  assign start_det = (state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;
  assign vote_tick = tick && (sub_cnt_q == SUB_VOTE);
  assign vote      = (samp0_q & samp1_q) | (samp0_q & rx_sync_q) | (samp1_q & rx_sync_q);
  assign last_data = (bit_cnt_q == DATA_LAST);
  assign last_stop = (bit_cnt_q == STOP_LAST);
  assign par_exp   = (PARITY == PARITY_ODD) ? ~(^shift_q) : (^shift_q);
  assign pop       = rx_valid && rx_ready;

  // Two-stage synchroniser on the asynchronous line plus one stage of history for edge detect.
  always_comb begin
    rx_meta_d = UART_RX;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  // Oversample tick divider; restarting on the start edge aligns sampling phase to each frame.
  always_comb begin
    div_cnt_d = div_cnt_q;
    tick      = 1'b0;
    if (start_det) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      tick      = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Sub-tick position within a bit; capture the two samples preceding the vote tick.
  always_comb begin
    sub_cnt_d = sub_cnt_q;
    samp0_d   = samp0_q;
    samp1_d   = samp1_q;
    if (start_det) begin
      sub_cnt_d = '0;
    end else if (tick) begin
      sub_cnt_d = sub_cnt_q + 1'b1;
      if (sub_cnt_q == SUB_SAMP0) begin
        samp0_d = rx_sync_q;
      end
      if (sub_cnt_q == SUB_SAMP1) begin
        samp1_d = rx_sync_q;
      end
    end
  end

  // Receive FSM next state; WAIT_HI keeps a held-low line from posing as a new start bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:    if (start_det) state_d = RX_START;
      RX_START:   if (vote_tick) state_d = vote ? RX_IDLE : RX_DATA;
      RX_DATA:    if (vote_tick && last_data) state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY:  if (vote_tick) state_d = RX_STOP;
      RX_STOP:    if (vote_tick && last_stop) state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HI;
      RX_WAIT_HI: if (rx_sync_q) state_d = RX_IDLE;
      default:    state_d = RX_IDLE;
    endcase
  end

  // Frame datapath: bit counter, LSB-first shift register and sticky error flags.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    if (start_det) begin
      bit_cnt_d = '0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
    end else if (vote_tick) begin
      case (state_q)
        RX_DATA: begin
          shift_d   = {vote, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = last_data ? '0 : bit_cnt_q + 1'b1;
        end
        RX_PARITY: begin
          perr_d = (vote != par_exp);
        end
        RX_STOP: begin
          if (!vote) begin
            ferr_d = 1'b1;
          end
          bit_cnt_d = last_stop ? '0 : bit_cnt_q + 1'b1;
        end
        default: begin
          bit_cnt_d = bit_cnt_q;
        end
      endcase
    end
  end

  // FSM outputs: write the frame on the last stop vote; flag a drop when full without a pop.
  always_comb begin
    push      = 1'b0;
    push_dat  = {ferr_q | ~vote, perr_q, shift_q};
    if ((state_q == RX_STOP) && vote_tick && last_stop) begin
      push = 1'b1;
    end
    overrun_d = push && fifo_full && !pop;
  end

  // Synchroniser registers reset to the idle line level.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider, sampler and frame datapath registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      sub_cnt_q <= '0;
      samp0_q   <= 1'b1;
      samp1_q   <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sub_cnt_q <= sub_cnt_d;
      samp0_q   <= samp0_d;
      samp1_q   <= samp1_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk   (sysclk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (rx_count)
  );

  assign {rx_ferr, rx_perr, rx_data} = head_dat;
  assign rx_valid = !fifo_empty;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Directed bench for the UART receiver: 8N1 instance and an even-parity instance share clock and reset.
// Line rate is scaled so one bit is 64 sysclk cycles (tick divider of 4 at 16x oversampling).
// Entries are recorded as {ferr, perr, data} whenever a pop handshake is seen.
module tb_uart_rx_fifo;

  localparam int CLK_HZ  = 100_000_000;
  localparam int BAUD_T  = 1_562_500;
  localparam int BIT_CYC = 64;

  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart_rx_p = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_ready_p = 1'b0;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_perr, rx_perr_p;
  logic       rx_ferr, rx_ferr_p;
  logic       rx_valid, rx_valid_p;
  logic [2:0] rx_count, rx_count_p;
  logic       overrun, overrun_p;

  int total = 0;
  int bad = 0;
  logic [9:0] popq[$];
  logic [9:0] popq_p[$];
  int ovr_cnt = 0;
  int ovr_cnt_p = 0;

  always #5 sysclk = ~sysclk;

  uart_rx_fifo #(
    .CLK_FREQ (CLK_HZ), .BAUD (BAUD_T), .OVS (16), .DATA_BITS (8),
    .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) dut (
    .sysclk (sysclk), .reset (reset), .UART_RX (uart_rx),
    .rx_data (rx_data), .rx_perr (rx_perr), .rx_ferr (rx_ferr),
    .rx_valid (rx_valid), .rx_ready (rx_ready), .rx_count (rx_count), .overrun (overrun)
  );

  uart_rx_fifo #(
    .CLK_FREQ (CLK_HZ), .BAUD (BAUD_T), .OVS (16), .DATA_BITS (8),
    .PARITY (2), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) dut_p (
    .sysclk (sysclk), .reset (reset), .UART_RX (uart_rx_p),
    .rx_data (rx_data_p), .rx_perr (rx_perr_p), .rx_ferr (rx_ferr_p),
    .rx_valid (rx_valid_p), .rx_ready (rx_ready_p), .rx_count (rx_count_p), .overrun (overrun_p)
  );

  // Record every pop handshake and count overrun pulses, sampled away from the active edge.
  always @(negedge sysclk) begin
    if (!reset && rx_valid && rx_ready) popq.push_back({rx_ferr, rx_perr, rx_data});
    if (!reset && rx_valid_p && rx_ready_p) popq_p.push_back({rx_ferr_p, rx_perr_p, rx_data_p});
    if (overrun) ovr_cnt++;
    if (overrun_p) ovr_cnt_p++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stop);
    return {6'b0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] f8e1(input logic [7:0] d, input logic par, input logic stop);
    return {5'b0, stop, par, d, 1'b0};
  endfunction

  task automatic idle_bits(input int n);
    repeat (n * BIT_CYC) @(posedge sysclk);
    #1;
  endtask

  // Drive n bits LSB first; the first bit changes 1 ns after the next rising edge.
  task automatic send_bits(input bit sel, input logic [15:0] bits, input int n);
    @(posedge sysclk);
    #1;
    for (int i = 0; i < n; i++) begin
      if (sel) uart_rx_p = bits[i];
      else     uart_rx   = bits[i];
      repeat (BIT_CYC) @(posedge sysclk);
      #1;
    end
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk); #1 rx_ready = 1'b1;
      @(posedge sysclk); #1 rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    total++; if (rx_count !== 3'd0) begin bad++; $display("FAIL reset_count got %0d want 0", rx_count); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got %h want 00", rx_data); end
    total++; if (rx_perr !== 1'b0) begin bad++; $display("FAIL reset_perr got %b want 0", rx_perr); end
    total++; if (rx_ferr !== 1'b0) begin bad++; $display("FAIL reset_ferr got %b want 0", rx_ferr); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
    total++; if (rx_valid_p !== 1'b0) begin bad++; $display("FAIL reset_valid_p got %b want 0", rx_valid_p); end
    total++; if (rx_count_p !== 3'd0) begin bad++; $display("FAIL reset_count_p got %0d want 0", rx_count_p); end
    @(posedge sysclk); #1 reset = 1'b0;
    idle_bits(1);
  endtask

  task automatic test_basic;
    int base = popq.size();
    int ob = ovr_cnt;
    rx_ready = 1'b1;
    send_bits(0, f8n1(8'h5A, 1'b1), 10);
    send_bits(0, f8n1(8'hC3, 1'b1), 10);
    idle_bits(1);
    rx_ready = 1'b0;
    @(negedge sysclk);
    total++; if (popq.size() - base !== 2) begin bad++; $display("FAIL basic_pops got %0d want 2", popq.size() - base); end
    if (popq.size() >= base + 2) begin
      total++; if (popq[base] !== 10'h05A) begin bad++; $display("FAIL basic_first got %h want 05A", popq[base]); end
      total++; if (popq[base+1] !== 10'h0C3) begin bad++; $display("FAIL basic_second got %h want 0C3", popq[base+1]); end
    end
    total++; if (ovr_cnt - ob !== 0) begin bad++; $display("FAIL basic_overrun got %0d want 0", ovr_cnt - ob); end
    total++; if (rx_count !== 3'd0) begin bad++; $display("FAIL basic_count got %0d want 0", rx_count); end
  endtask

  task automatic test_glitch;
    int base = popq.size();
    @(posedge sysclk); #1 uart_rx = 1'b0;
    repeat (10) @(posedge sysclk);
    #1 uart_rx = 1'b1;
    idle_bits(2);
    @(negedge sysclk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got %b want 0", rx_valid); end
    total++; if (rx_count !== 3'd0) begin bad++; $display("FAIL glitch_count got %0d want 0", rx_count); end
    send_bits(0, f8n1(8'hA5, 1'b1), 10);
    idle_bits(1);
    @(negedge sysclk);
    total++; if (rx_count !== 3'd1) begin bad++; $display("FAIL glitch_after_count got %0d want 1", rx_count); end
    pop_n(1);
    @(negedge sysclk);
    total++; if (popq.size() - base !== 1) begin bad++; $display("FAIL glitch_pops got %0d want 1", popq.size() - base); end
    if (popq.size() > base) begin
      total++; if (popq[base] !== 10'h0A5) begin bad++; $display("FAIL glitch_data got %h want 0A5", popq[base]); end
    end
  endtask

  task automatic test_parity;
    int base = popq_p.size();
    rx_ready_p = 1'b1;
    send_bits(1, f8e1(8'h07, 1'b0, 1'b1), 11);
    send_bits(1, f8e1(8'h07, 1'b1, 1'b1), 11);
    send_bits(1, f8e1(8'h03, 1'b0, 1'b1), 11);
    idle_bits(1);
    rx_ready_p = 1'b0;
    @(negedge sysclk);
    total++; if (popq_p.size() - base !== 3) begin bad++; $display("FAIL parity_pops got %0d want 3", popq_p.size() - base); end
    if (popq_p.size() >= base + 3) begin
      total++; if (popq_p[base] !== 10'h107) begin bad++; $display("FAIL parity_bad got %h want 107", popq_p[base]); end
      total++; if (popq_p[base+1] !== 10'h007) begin bad++; $display("FAIL parity_good1 got %h want 007", popq_p[base+1]); end
      total++; if (popq_p[base+2] !== 10'h003) begin bad++; $display("FAIL parity_good0 got %h want 003", popq_p[base+2]); end
    end
    total++; if (rx_count !== 3'd0) begin bad++; $display("FAIL parity_other_count got %0d want 0", rx_count); end
  endtask

  task automatic test_stuck_low;
    int base = popq.size();
    send_bits(0, f8n1(8'h81, 1'b0), 10);
    idle_bits(20);
    @(negedge sysclk);
    total++; if (rx_count !== 3'd1) begin bad++; $display("FAIL stuck_count got %0d want 1", rx_count); end
    total++; if ({rx_valid, rx_ferr, rx_perr, rx_data} !== 11'b1_1_0_10000001) begin
      bad++; $display("FAIL stuck_head got v%b f%b p%b %h want v1 f1 p0 81", rx_valid, rx_ferr, rx_perr, rx_data);
    end
    @(posedge sysclk); #1 uart_rx = 1'b1;
    idle_bits(2);
    @(negedge sysclk);
    total++; if (rx_count !== 3'd1) begin bad++; $display("FAIL stuck_release_count got %0d want 1", rx_count); end
    send_bits(0, f8n1(8'h42, 1'b1), 10);
    idle_bits(1);
    @(negedge sysclk);
    total++; if (rx_count !== 3'd2) begin bad++; $display("FAIL stuck_new_count got %0d want 2", rx_count); end
    pop_n(2);
    @(negedge sysclk);
    total++; if (popq.size() - base !== 2) begin bad++; $display("FAIL stuck_pops got %0d want 2", popq.size() - base); end
    if (popq.size() >= base + 2) begin
      total++; if (popq[base] !== 10'h281) begin bad++; $display("FAIL stuck_first got %h want 281", popq[base]); end
      total++; if (popq[base+1] !== 10'h042) begin bad++; $display("FAIL stuck_second got %h want 042", popq[base+1]); end
    end
  endtask

  task automatic test_overrun;
    int base = popq.size();
    int ob = ovr_cnt;
    for (int i = 1; i <= 4; i++) send_bits(0, f8n1(8'(i), 1'b1), 10);
    @(negedge sysclk);
    total++; if (ovr_cnt - ob !== 0) begin bad++; $display("FAIL ovr_before5 got %0d want 0", ovr_cnt - ob); end
    send_bits(0, f8n1(8'h05, 1'b1), 10);
    idle_bits(1);
    @(negedge sysclk);
    total++; if (rx_count !== 3'd4) begin bad++; $display("FAIL ovr_count got %0d want 4", rx_count); end
    total++; if (ovr_cnt - ob !== 1) begin bad++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - ob); end
    pop_n(5);
    @(negedge sysclk);
    total++; if (popq.size() - base !== 4) begin bad++; $display("FAIL ovr_pops got %0d want 4", popq.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (popq.size() > base + i) begin
        total++; if (popq[base+i] !== 10'(i + 1)) begin bad++; $display("FAIL ovr_entry%0d got %h want %h", i, popq[base+i], 10'(i + 1)); end
      end
    end
    // Refill, then pop in exactly the cycle the fifth frame is written (mid-sample of its stop bit).
    base = popq.size();
    ob = ovr_cnt;
    for (int i = 1; i <= 4; i++) send_bits(0, f8n1(8'(8'h10 + i), 1'b1), 10);
    fork
      send_bits(0, f8n1(8'h15, 1'b1), 10);
      begin
        @(posedge sysclk);
        repeat (618) @(posedge sysclk);
        #1 rx_ready = 1'b1;
        @(posedge sysclk);
        #1 rx_ready = 1'b0;
      end
    join
    idle_bits(1);
    @(negedge sysclk);
    total++; if (rx_count !== 3'd4) begin bad++; $display("FAIL ovr2_count got %0d want 4", rx_count); end
    total++; if (ovr_cnt - ob !== 0) begin bad++; $display("FAIL ovr2_pulses got %0d want 0", ovr_cnt - ob); end
    pop_n(4);
    @(negedge sysclk);
    total++; if (popq.size() - base !== 5) begin bad++; $display("FAIL ovr2_pops got %0d want 5", popq.size() - base); end
    for (int i = 0; i < 5; i++) begin
      if (popq.size() > base + i) begin
        total++; if (popq[base+i] !== 10'(8'h11 + i)) begin bad++; $display("FAIL ovr2_entry%0d got %h want %h", i, popq[base+i], 10'(8'h11 + i)); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int base = popq.size();
    // Start bit and first data bit of 0x3C, then reset halfway through the second (low) data bit.
    send_bits(0, 16'h0000, 2);
    repeat (32) @(posedge sysclk);
    #1 reset = 1'b1;
    uart_rx = 1'b1;
    repeat (20) @(posedge sysclk);
    #1 reset = 1'b0;
    idle_bits(12);
    @(negedge sysclk);
    total++; if (rx_count !== 3'd0) begin bad++; $display("FAIL rstmid_count got %0d want 0", rx_count); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got %b want 0", rx_valid); end
    send_bits(0, f8n1(8'h99, 1'b1), 10);
    idle_bits(1);
    @(negedge sysclk);
    total++; if (rx_count !== 3'd1) begin bad++; $display("FAIL rstmid_after_count got %0d want 1", rx_count); end
    pop_n(2);
    @(negedge sysclk);
    total++; if (popq.size() - base !== 1) begin bad++; $display("FAIL rstmid_pops got %0d want 1", popq.size() - base); end
    if (popq.size() > base) begin
      total++; if (popq[base] !== 10'h099) begin bad++; $display("FAIL rstmid_data got %h want 099", popq[base]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_stuck_low();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
